// File: rtl/ysyx_220053_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the memory (slave).
// The master holds one request at a time and expects a single response beat per accepted request.
interface ysyx_220053_fetch_unit_if #(
    parameter int unsigned PC_W   = 64,
    parameter int unsigned DATA_W = 64
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [DATA_W-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/ysyx_220053_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding imem read at a time and
// queues {pc, instr} pairs in a small FIFO for decode; supports redirect/flush and stall.
module ysyx_220053_fetch_unit #(
    parameter int unsigned     PC_W     = 64,
    parameter int unsigned     DATA_W   = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000),
    parameter int unsigned     FQ_DEPTH = 4,
    localparam int unsigned    PTR_W    = $clog2(FQ_DEPTH),
    localparam int unsigned    CNT_W    = $clog2(FQ_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_running,
    input  logic                   i_redirect_valid,
    input  logic [PC_W-1:0]        i_redirect_pc,
    ysyx_220053_fetch_unit_if.master imem,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [PC_W-1:0]        o_out_pc,
    output logic [31:0]            o_out_instr,
    output logic [CNT_W-1:0]       o_fq_count
);

    localparam logic [PC_W-1:0] ADDR_MASK = ~PC_W'(DATA_W / 8 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [PC_W-1:0]   r_pc, w_pc_nxt;
    logic [PC_W-1:0]   r_req_pc, w_req_pc_nxt;
    logic              r_stale, w_stale_nxt;

    logic [PC_W-1:0]   r_fq_pc    [FQ_DEPTH];
    logic [31:0]       r_fq_instr [FQ_DEPTH];
    logic [PTR_W-1:0]  r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_push, w_pop;
    logic [CNT_W:0]    w_occ;
    logic              w_slot_free, w_can_issue;
    logic [31:0]       w_instr;

    generate
        if (DATA_W == 64) begin : g_sel64
            assign w_instr = r_req_pc[2] ? imem.imem_resp_data[63:32] : imem.imem_resp_data[31:0];
        end else begin : g_sel32
            assign w_instr = imem.imem_resp_data[31:0];
        end
    endgenerate

    // Occupancy includes an entry landing this cycle so a response always finds a free slot.
    assign w_push      = (r_state == S_WAIT) && imem.imem_resp_valid && !r_stale && !i_redirect_valid;
    assign w_pop       = o_out_valid && i_out_ready && !i_redirect_valid;
    assign w_occ       = {1'b0, r_count} + {{CNT_W{1'b0}}, w_push};
    assign w_slot_free = w_occ < (CNT_W + 1)'(FQ_DEPTH);
    assign w_can_issue = i_running && !i_redirect_valid && w_slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_stale  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_req_pc <= w_req_pc_nxt;
            r_stale  <= w_stale_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_req_pc_nxt = r_req_pc;
        w_stale_nxt  = r_stale;
        case (r_state)
            S_IDLE: begin
                if (w_can_issue) begin
                    w_state_nxt  = S_REQ;
                    w_req_pc_nxt = r_pc;
                end
            end
            S_REQ: begin
                if (i_redirect_valid) begin
                    w_stale_nxt = 1'b1;
                end
                // A request made stale by a redirect must not advance the new PC.
                if (imem.imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                    if (!r_stale && !i_redirect_valid) begin
                        w_pc_nxt = r_pc + PC_W'(4);
                    end
                end
            end
            S_WAIT: begin
                if (imem.imem_resp_valid) begin
                    w_stale_nxt = 1'b0;
                    if (w_can_issue) begin
                        w_state_nxt  = S_REQ;
                        w_req_pc_nxt = r_pc;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (i_redirect_valid) begin
                    w_stale_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_redirect_valid) begin
            w_pc_nxt = i_redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fq_pc[r_wptr]    <= r_req_pc;
            r_fq_instr[r_wptr] <= w_instr;
        end
    end

    assign imem.imem_req_valid = (r_state == S_REQ);
    assign imem.imem_req_addr  = r_req_pc & ADDR_MASK;

    assign o_out_valid = (r_count != '0);
    assign o_out_pc    = r_fq_pc[r_rptr];
    assign o_out_instr = r_fq_instr[r_rptr];
    assign o_fq_count  = r_count;

endmodule
